// File: rtl/wb_ll_arbiter.sv
// Long-latency writeback arbiter: round-robin pick among NUM_REQ result sources
// into one registered writeback port with stall backpressure and flush.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_flush           drop the held writeback and suppress grants
//   i_req_ready/rd/tag/data  per-source result offer (flattened vectors)
//   o_req_grant       one-hot combinational grant, consumes the source result
//   i_wb_stall        downstream busy, hold o_wb_* while valid
//   o_wb_valid/we/rd/tag/data  registered writeback request
module wb_ll_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int TAG_W   = 6,
   parameter int RD_W    = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   input  logic [NUM_REQ-1:0]        i_req_ready,
   input  logic [NUM_REQ*RD_W-1:0]   i_req_rd,
   input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_grant,
   input  logic                      i_wb_stall,
   output logic                      o_wb_valid,
   output logic                      o_wb_we,
   output logic [RD_W-1:0]           o_wb_rd,
   output logic [TAG_W-1:0]          o_wb_tag,
   output logic [DATA_W-1:0]         o_wb_data
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IW-1:0]     last_q;
   logic [IW-1:0]     sel;
   logic [IW-1:0]     cand;
   logic              hit;
   logic              opp;
   logic              win;
   logic [RD_W-1:0]   sel_rd;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;
   int                idx;

   // Reset is folded in so the grant stays low while reset is held.
   assign opp = i_rst_n & ~i_flush & (~o_wb_valid | ~i_wb_stall);
   assign win = opp & hit;

   // First ready source searching upward from the one after last_grant.
   always_comb begin
      hit  = 1'b0;
      sel  = '0;
      cand = '0;
      idx  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(last_q) + k) % NUM_REQ;
         cand = IW'(idx);
         if (!hit && i_req_ready[cand]) begin
            hit = 1'b1;
            sel = cand;
         end
      end
   end

   always_comb begin
      o_req_grant = '0;
      if (win) o_req_grant[sel] = 1'b1;
   end

   assign sel_rd   = i_req_rd[int'(sel)*RD_W +: RD_W];
   assign sel_tag  = i_req_tag[int'(sel)*TAG_W +: TAG_W];
   assign sel_data = i_req_data[int'(sel)*DATA_W +: DATA_W];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_rd    <= '0;
         o_wb_tag   <= '0;
         o_wb_data  <= '0;
         last_q     <= IW'(NUM_REQ - 1);
      end else if (i_flush) begin
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
      end else if (win) begin
         o_wb_valid <= 1'b1;
         o_wb_we    <= (sel_rd != '0);
         o_wb_rd    <= sel_rd;
         o_wb_tag   <= sel_tag;
         o_wb_data  <= sel_data;
         last_q     <= sel;
      end else if (opp) begin
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_ll_arbiter.sv
// Directed bench for wb_ll_arbiter: single request, round-robin,
// backpressure, flush, rd=0 and asynchronous reset.
module tb_wb_ll_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int TW = 6;
   localparam int RW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic [N-1:0]    ready;
   logic [N*RW-1:0] rd_v;
   logic [N*TW-1:0] tag_v;
   logic [N*DW-1:0] data_v;
   logic [N-1:0]    grant;
   logic            stall;
   logic            wb_valid;
   logic            wb_we;
   logic [RW-1:0]   wb_rd;
   logic [TW-1:0]   wb_tag;
   logic [DW-1:0]   wb_data;

   int vectors = 0;
   int miss    = 0;

   always #5 clk = ~clk;

   wb_ll_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .RD_W(RW)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_flush(flush),
      .i_req_ready(ready),
      .i_req_rd(rd_v),
      .i_req_tag(tag_v),
      .i_req_data(data_v),
      .o_req_grant(grant),
      .i_wb_stall(stall),
      .o_wb_valid(wb_valid),
      .o_wb_we(wb_we),
      .o_wb_rd(wb_rd),
      .o_wb_tag(wb_tag),
      .o_wb_data(wb_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      flush  = 1'b0;
      stall  = 1'b0;
      ready  = 4'b1111;
      rd_v   = '0;
      tag_v  = '0;
      data_v = '0;
      #3;
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_we",    64'(wb_we),    64'd0);
      chk("rst_rd",    64'(wb_rd),    64'd0);
      chk("rst_data",  wb_data,       64'd0);
      chk("rst_grant", 64'(grant),    64'd0);
      ready = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // single request from source 2
      rd_v[2*RW +: RW]   = 5'd7;
      tag_v[2*TW +: TW]  = 6'd3;
      data_v[2*DW +: DW] = 64'hDEAD;
      ready = 4'b0100;
      #1;
      chk("single_grant", 64'(grant), 64'b0100);
      tick();
      ready = '0;
      #1;
      chk("single_valid", 64'(wb_valid), 64'd1);
      chk("single_we",    64'(wb_we),    64'd1);
      chk("single_rd",    64'(wb_rd),    64'd7);
      chk("single_tag",   64'(wb_tag),   64'd3);
      chk("single_data",  wb_data,       64'hDEAD);
      chk("idle_grant",   64'(grant),    64'd0);
      tick();
      chk("idle_valid",   64'(wb_valid), 64'd0);

      // reset pulse so round-robin starts at 0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         rd_v[i*RW +: RW]   = RW'(i + 1);
         tag_v[i*TW +: TW]  = TW'(i + 10);
         data_v[i*DW +: DW] = 64'(i + 100);
      end
      ready = 4'b1111;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("rr_grant", 64'(grant), 64'(1 << (c % N)));
         tick();
         chk("rr_valid", 64'(wb_valid), 64'd1);
         chk("rr_rd",    64'(wb_rd),    64'((c % N) + 1));
      end

      // backpressure with source 0 held, last grant 0
      stall = 1'b1;
      ready = 4'b0011;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("bp_grant", 64'(grant),    64'd0);
         chk("bp_valid", 64'(wb_valid), 64'd1);
         chk("bp_rd",    64'(wb_rd),    64'd1);
         chk("bp_tag",   64'(wb_tag),   64'd10);
         chk("bp_data",  wb_data,       64'd100);
         tick();
      end
      stall = 1'b0;
      #1;
      chk("bp_release_grant", 64'(grant), 64'b0010);
      tick();
      chk("bp_rd_after", 64'(wb_rd), 64'd2);

      // flush during stall
      stall = 1'b1;
      ready = 4'b1000;
      flush = 1'b1;
      #1;
      chk("fl_grant", 64'(grant), 64'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_valid", 64'(wb_valid), 64'd0);
      chk("fl_after_grant", 64'(grant), 64'b1000);
      tick();
      chk("fl_src3_valid", 64'(wb_valid), 64'd1);
      chk("fl_src3_rd",    64'(wb_rd),    64'd4);
      stall = 1'b0;

      // rd = 0 suppresses write enable
      rd_v[0 +: RW] = '0;
      ready = 4'b0001;
      #1;
      chk("rd0_grant", 64'(grant), 64'b0001);
      tick();
      chk("rd0_valid", 64'(wb_valid), 64'd1);
      chk("rd0_we",    64'(wb_we),    64'd0);
      chk("rd0_tag",   64'(wb_tag),   64'd10);

      // async reset mid-cycle while a stalled request is held
      ready = 4'b0010;
      tick();
      stall = 1'b1;
      ready = 4'b1111;
      #1;
      chk("ar_pre_valid", 64'(wb_valid), 64'd1);
      chk("ar_pre_rd",    64'(wb_rd),    64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(wb_valid), 64'd0);
      chk("ar_we",    64'(wb_we),    64'd0);
      chk("ar_rd",    64'(wb_rd),    64'd0);
      chk("ar_grant", 64'(grant),    64'd0);
      tick();
      rst_n = 1'b1;
      ready = 4'b0110;
      #1;
      chk("ar_restart_grant", 64'(grant), 64'b0010);
      ready = 4'b0111;
      #1;
      chk("ar_idx0_grant", 64'(grant), 64'b0001);
      tick();
      chk("ar_restart_rd", 64'(wb_rd), 64'd0);
      chk("ar_restart_valid", 64'(wb_valid), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
